// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between two ROM requesters (CPU fetch, debug dump), the arbiter and the ROM.
`default_nettype none

interface rom_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_rdy;
  logic                  cpu_valid;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  dbg_req;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic                  dbg_ack;
  logic                  dbg_valid;
  logic [DATA_WIDTH-1:0] dbg_dout;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_dout;

  // Requester/ROM side of the arbiter
  modport master (
    output cpu_req, cpu_addr, dbg_req, dbg_addr, rom_dout,
    input  cpu_rdy, cpu_valid, cpu_dout, dbg_ack, dbg_valid, dbg_dout, rom_addr
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_addr, dbg_req, dbg_addr, rom_dout,
    output cpu_rdy, cpu_valid, cpu_dout, dbg_ack, dbg_valid, dbg_dout, rom_addr
  );
endinterface

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// Shares one 1-cycle-latency ROM between a priority CPU port and a debug port with bounded
// starvation; the registered owner tag routes each returned byte to exactly one requester.
`default_nettype none

module rom_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  rom_port_arbiter_if.slave   bus
);
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } owner_t;

  owner_t                state;
  owner_t                state_next;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  starve;
  logic                  dbg_gnt;
  logic                  cpu_gnt;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // Grants are suppressed during reset so nothing new is launched into the ROM
  always_comb begin
    starve   = (wait_cnt == CNT_MAX);
    dbg_gnt  = ~rst & bus.dbg_req & (~bus.cpu_req | starve);
    cpu_gnt  = ~rst & bus.cpu_req & ~dbg_gnt;
    gnt_addr = dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
    rd_data  = bus.rom_dout;
  end

  assign bus.dbg_ack   = dbg_gnt;
  assign bus.cpu_rdy   = ~(bus.cpu_req & dbg_gnt);
  assign bus.rom_addr  = gnt_addr;
  assign bus.cpu_dout  = rd_data;
  assign bus.dbg_dout  = rd_data;
  // Gating with rst drops a read that is in flight when reset arrives
  assign bus.cpu_valid = (state == CPU_RD) & ~rst;
  assign bus.dbg_valid = (state == DBG_RD) & ~rst;

  always_comb begin
    state_next = IDLE;
    if (dbg_gnt) begin
      state_next = DBG_RD;
    end else if (cpu_gnt) begin
      state_next = CPU_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.dbg_req || dbg_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// Randomized and directed checks of rom_port_arbiter (MAX_WAIT=4 and MAX_WAIT=0) against a reference model.
`default_nettype none

module tb_rom_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();
  rom_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

  rom_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  rom_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  logic [DW-1:0] rom [256];
  always @(posedge clk) begin
    bus4.rom_dout <= rom[bus4.rom_addr];
    bus0.rom_dout <= rom[bus0.rom_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles debug has waited, and which requester owns the next returned byte
  int            maxw   [2] = '{4, 0};
  int            waited [2] = '{0, 0};
  int            owner  [2] = '{0, 0};   // 0 none, 1 cpu, 2 debug
  logic [DW-1:0] edata  [2];

  task automatic step(input logic r, input logic cr, input logic [AW-1:0] ca,
                      input logic dr, input logic [AW-1:0] da);
    logic          gd, gc;
    logic          o_ack, o_rdy, o_cv, o_dv;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_cd, o_dd;
    @(negedge clk);
    rst = r;
    bus4.cpu_req = cr; bus4.cpu_addr = ca; bus4.dbg_req = dr; bus4.dbg_addr = da;
    bus0.cpu_req = cr; bus0.cpu_addr = ca; bus0.dbg_req = dr; bus0.dbg_addr = da;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_ack = bus4.dbg_ack; o_rdy = bus4.cpu_rdy; o_addr = bus4.rom_addr;
        o_cv = bus4.cpu_valid; o_dv = bus4.dbg_valid; o_cd = bus4.cpu_dout; o_dd = bus4.dbg_dout;
      end else begin
        o_ack = bus0.dbg_ack; o_rdy = bus0.cpu_rdy; o_addr = bus0.rom_addr;
        o_cv = bus0.cpu_valid; o_dv = bus0.dbg_valid; o_cd = bus0.cpu_dout; o_dd = bus0.dbg_dout;
      end
      gd = !r && dr && (!cr || waited[k] >= maxw[k]);
      gc = !r && cr && !gd;
      check($sformatf("dbg_ack_mw%0d", maxw[k]), 32'(o_ack), 32'(gd));
      check($sformatf("cpu_rdy_mw%0d", maxw[k]), 32'(o_rdy), 32'(!(cr && gd)));
      check($sformatf("rom_addr_mw%0d", maxw[k]), 32'(o_addr), 32'(gd ? da : ca));
      check($sformatf("cpu_valid_mw%0d", maxw[k]), 32'(o_cv), 32'(!r && owner[k] == 1));
      check($sformatf("dbg_valid_mw%0d", maxw[k]), 32'(o_dv), 32'(!r && owner[k] == 2));
      if (!r && owner[k] == 1) check($sformatf("cpu_dout_mw%0d", maxw[k]), 32'(o_cd), 32'(edata[k]));
      if (!r && owner[k] == 2) check($sformatf("dbg_dout_mw%0d", maxw[k]), 32'(o_dd), 32'(edata[k]));
      owner[k] = gd ? 2 : (gc ? 1 : 0);
      edata[k] = rom[gd ? da : ca];
      if (r || !dr || gd) waited[k] = 0;
      else if (waited[k] < maxw[k]) waited[k] = waited[k] + 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
    bus4.cpu_req = 0; bus4.cpu_addr = '0; bus4.dbg_req = 0; bus4.dbg_addr = '0;
    bus0.cpu_req = 0; bus0.cpu_addr = '0; bus0.dbg_req = 0; bus0.dbg_addr = '0;

    // Reset state, including rst gating of grants
    step(1, 1, 8'h33, 1, 8'h44);
    check("rst_cpu_rdy", 32'(bus4.cpu_rdy), 1);
    check("rst_dbg_ack", 32'(bus4.dbg_ack), 0);
    check("rst_rom_addr", 32'(bus4.rom_addr), 32'h33);
    step(1, 0, 8'h00, 0, 8'h00);

    // CPU only at FF
    step(0, 1, 8'hFF, 0, 8'h00);
    step(0, 1, 8'hFF, 0, 8'h00);
    check("t1_cpu_valid", 32'(bus4.cpu_valid), 1);
    check("t1_cpu_dout", 32'(bus4.cpu_dout), 32'(rom[8'hFF]));
    step(0, 0, 8'h00, 0, 8'h00);

    // Debug only at 00
    step(0, 0, 8'h00, 1, 8'h00);
    check("t2_dbg_ack", 32'(bus4.dbg_ack), 1);
    step(0, 0, 8'h00, 0, 8'h00);
    check("t2_dbg_valid", 32'(bus4.dbg_valid), 1);
    check("t2_dbg_dout", 32'(bus4.dbg_dout), 32'(rom[8'h00]));

    // Starvation bound with continuous CPU traffic; MAX_WAIT=0 instance collides here too
    step(0, 1, 8'h10, 1, 8'h20);
    check("t4_rom_addr", 32'(bus0.rom_addr), 32'h20);
    check("t4_cpu_rdy", 32'(bus0.cpu_rdy), 0);
    check("t3_cycle0_cpu_wins", 32'(bus4.dbg_ack), 0);
    for (int c = 1; c < 4; c++) step(0, 1, 8'(c), 1, 8'h20);
    step(0, 1, 8'h04, 1, 8'h20);
    check("t3_forced_ack", 32'(bus4.dbg_ack), 1);
    check("t3_forced_rdy", 32'(bus4.cpu_rdy), 0);
    step(0, 1, 8'h05, 1, 8'h21);
    check("t3_cpu_again", 32'(bus4.cpu_rdy), 1);
    check("t3_dbg_valid", 32'(bus4.dbg_valid), 1);
    step(0, 0, 8'h00, 0, 8'h00);

    // Reset with a CPU read in flight
    step(0, 1, 8'h55, 0, 8'h00);
    step(1, 1, 8'h56, 0, 8'h00);
    check("t5_cpu_valid_dropped", 32'(bus4.cpu_valid), 0);
    step(0, 0, 8'h00, 0, 8'h00);

    // Debug withdraws after two cycles behind the CPU
    step(0, 1, 8'h60, 1, 8'h70);
    step(0, 1, 8'h61, 1, 8'h70);
    for (int c = 0; c < 6; c++) step(0, 1, 8'(8'h62 + c), 0, 8'h00);
    check("t6_no_dbg_valid", 32'(bus4.dbg_valid), 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), AW'($urandom),
           ($urandom_range(0, 2) != 0), AW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
